// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side arbiter.
// Holds the arbiter state encoding and the round-robin pointer increment.
package uart_pkg;

  // Arbiter states; HDR is only reachable when UART_ARB_ID_HEADER_EN is defined.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HDR   = 2'd2,
    PASS  = 2'd3
  } arb_state_t;

  // Wrap-around increment of a requester index: num_req-1 wraps to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
    int unsigned nxt;
    if (ptr >= (num_req - 32'd1)) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin selector: finds the first asserted request at or above rr_ptr,
// wrapping past the top index back to 0. Purely combinational.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    pick
);

  logic [ID_W-1:0] idx_s;

  // Scan NUM_REQ positions starting at rr_ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    pick  = {ID_W{1'b0}};
    idx_s = {ID_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = ID_W'((32'(rr_ptr) + 32'(i)) % 32'(NUM_REQ));
      if (!found && req[idx_s]) begin
        found = 1'b1;
        pick  = idx_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one uart_tx between NUM_REQ
// requesters. A requester is locked in from grant until its last word is
// accepted, then the search pointer moves past it.
// Optional macro UART_ARB_ID_HEADER_EN: prefixes each frame with one word
// carrying the granted requester index.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WORD_LENGTH = 8,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [WORD_LENGTH-1:0]         tx_data,
  output logic                           tx_data_valid,
  input  logic                           tx_data_ready,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy
);

  arb_state_t state_r, state_s;
  logic [ID_W-1:0] grant_id_r, grant_id_s;
  logic [ID_W-1:0] rr_ptr_r, rr_ptr_s;
  logic            pick_found_s;
  logic [ID_W-1:0] pick_idx_s;

  logic [NUM_REQ-1:0]     req_ready_s;
  logic [WORD_LENGTH-1:0] tx_data_s;
  logic                   tx_data_valid_s;
  logic                   busy_s;

  logic [WORD_LENGTH-1:0] req_word_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_word_s[g] = req_data[g*WORD_LENGTH +: WORD_LENGTH];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_r),
    .found  (pick_found_s),
    .pick   (pick_idx_s)
  );

  // Next-state, grant/pointer update and output decode for the arbiter FSM.
  always_comb begin
    state_s         = state_r;
    grant_id_s      = grant_id_r;
    rr_ptr_s        = rr_ptr_r;
    req_ready_s     = {NUM_REQ{1'b0}};
    tx_data_s       = {WORD_LENGTH{1'b0}};
    tx_data_valid_s = 1'b0;
    busy_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          grant_id_s = pick_idx_s;
          state_s    = GRANT;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        busy_s = 1'b1;
`ifdef UART_ARB_ID_HEADER_EN
        state_s = HDR;
`else
        state_s = PASS;
`endif
      end
`ifdef UART_ARB_ID_HEADER_EN
      HDR: begin
        busy_s          = 1'b1;
        tx_data_s       = WORD_LENGTH'(grant_id_r);
        tx_data_valid_s = 1'b1;
        if (tx_data_ready) begin
          state_s = PASS;
        end else begin
          state_s = HDR;
        end
      end
`endif
      PASS: begin
        busy_s                  = 1'b1;
        tx_data_s               = req_word_s[grant_id_r];
        tx_data_valid_s         = req_valid[grant_id_r];
        req_ready_s[grant_id_r] = tx_data_ready;
        // A stalled requester keeps the lock; only its last accepted word frees it.
        if (req_valid[grant_id_r] && tx_data_ready && req_last[grant_id_r]) begin
          state_s  = IDLE;
          rr_ptr_s = ID_W'(rr_next(32'(grant_id_r), $unsigned(NUM_REQ)));
        end else begin
          state_s = PASS;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, grant index and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      grant_id_r <= {ID_W{1'b0}};
      rr_ptr_r   <= {ID_W{1'b0}};
    end else begin
      state_r    <= state_s;
      grant_id_r <= grant_id_s;
      rr_ptr_r   <= rr_ptr_s;
    end
  end

  assign req_ready     = req_ready_s;
  assign tx_data       = tx_data_s;
  assign tx_data_valid = tx_data_valid_s;
  assign grant_id      = grant_id_r;
  assign busy          = busy_s;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requesters are loaded with whole frames, a
// frame-level round-robin model predicts the byte stream on the uart side,
// and random tx_data_ready / mid-frame bubbles exercise the handshakes.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   tx_data;
  logic           tx_data_valid;
  logic           tx_data_ready = 1'b0;
  logic [1:0]     grant_id;
  logic           busy;

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .WORD_LENGTH (W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           src;
    bit           hdr;
    bit           last;
  } exp_t;

  logic [W:0] rq [N][$];   // pending words per requester: {last, data}
  int         bub [N];     // idle cycles before presenting the next word
  exp_t       exp_q [$];   // expected uart byte stream

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;
  int last_src = 0;
  int se = 0;              // samples since the arbiter returned to idle
  int stall_r = -1;
  int stall_len = 0;
  int max_bub = 0;
  bit pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic add(input int r, input logic [W-1:0] d, input bit last);
    rq[r].push_back({last, d});
  endtask

  // Frame-level model: pick the first requester with work from the pointer
  // upward, send its whole frame, move the pointer just past it.
  task automatic build_model();
    logic [W:0] cq [N][$];
    logic [W:0] w;
    exp_t       e;
    int         sel;
    bit         found;
    for (int i = 0; i < N; i++) cq[i] = rq[i];
    forever begin
      found = 1'b0;
      sel = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && cq[(m_ptr + k) % N].size() > 0) begin
          found = 1'b1;
          sel = (m_ptr + k) % N;
        end
      end
      if (!found) break;
`ifdef UART_ARB_ID_HEADER_EN
      e.data = W'(sel); e.src = sel; e.hdr = 1'b1; e.last = 1'b0;
      exp_q.push_back(e);
`endif
      do begin
        w = cq[sel].pop_front();
        e.data = w[W-1:0]; e.src = sel; e.hdr = 1'b0; e.last = w[W];
        exp_q.push_back(e);
      end while (!w[W]);
      m_ptr = (sel + 1) % N;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && bub[i] == 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = rq[i][0][W-1:0];
        req_last[i]        = rq[i][0][W];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*W +: W] = W'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
    tx_data_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      bub[i] = 0;
    end
    exp_q.delete();
    stall_r = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    flush();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ptr = 0;
    last_src = 0;
    se = 1;
  endtask

  task automatic run(input int budget, input int stop_words);
    int         cyc = 0;
    int         words = 0;
    bit         hs [N];
    bit         any_q;
    exp_t       e;
    logic [N-1:0] oh;
    logic [W:0] w;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) hs[i] = req_valid[i] && req_ready[i];
      if (exp_q.size() > 0) begin
        oh = '0;
        oh[exp_q[0].src] = 1'b1;
        chk("ready_iso", 32'(req_ready & ~oh), 32'd0);
      end
      if (se == 1) begin
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(tx_data_valid), 32'd0);
        chk("idle_gid", 32'(grant_id), 32'(last_src));
        pend = 1'b0;
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) pend = 1'b1;
      end else if (se == 2) begin
        chk("grant_busy", 32'(busy), 32'(pend));
        chk("grant_valid", 32'(tx_data_valid), 32'd0);
      end else if (se == 3) begin
        chk("first_valid", 32'(tx_data_valid), 32'(pend));
      end
      if (se > 0 && se < 4) se++;
      if (tx_data_valid && tx_data_ready) begin
        words++;
        chk("xfer_busy", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e.data));
          chk("grant_id", 32'(grant_id), 32'(e.src));
          oh = '0;
          if (!e.hdr) oh[e.src] = 1'b1;
          chk(e.hdr ? "hdr_ready" : "ready_sel", 32'(req_ready), 32'(oh));
          last_src = e.src;
          if (e.last && !e.hdr) se = 1;
        end
      end
      cyc++;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          w = rq[i].pop_front();
          if (!w[W] && rq[i].size() > 0) begin
            if (i == stall_r) begin
              bub[i] = stall_len;
              stall_r = -1;
            end else if (max_bub > 0 && $urandom_range(0, 2) == 0) begin
              bub[i] = $urandom_range(1, max_bub);
            end
          end
        end else if (bub[i] > 0) begin
          bub[i]--;
        end
      end
      drive();
      if (stop_words > 0 && words >= stop_words) return;
      any_q = 1'b0;
      for (int i = 0; i < N; i++) if (rq[i].size() > 0) any_q = 1'b1;
      if (exp_q.size() == 0 && !any_q && se >= 4) return;
      if (cyc >= budget) begin
        chk("timeout_left", 32'(exp_q.size()), 32'd0);
        flush();
        drive();
        return;
      end
    end
  endtask

  initial begin
    int abort_words;
    int nf;
    int nw;
    for (int i = 0; i < N; i++) bub[i] = 0;
    do_reset();

    // One two-word frame from requester 1; pointer ends at 2.
    add(1, 8'h48, 1'b0); add(1, 8'h69, 1'b1);
    build_model(); drive(); run(500, 0);

    // Requester 3 stalls 50 cycles mid-frame while requester 0 waits.
    stall_r = 3; stall_len = 50;
    add(3, 8'hAA, 1'b0); add(3, 8'h55, 1'b1); add(0, 8'hC3, 1'b1);
    build_model(); drive(); run(1000, 0);

    // Simultaneous requests right after reset: index 0 first.
    do_reset();
    add(0, 8'h01, 1'b1); add(2, 8'h7E, 1'b1);
    build_model(); drive(); run(500, 0);

    // Fairness: every requester keeps one-word frames queued.
    do_reset();
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < N; i++) add(i, W'($urandom), 1'b1);
    build_model(); drive(); run(1000, 0);

    // Move the pointer to 1, then abandon a frame by reset mid-word.
    add(0, 8'h5A, 1'b1);
    build_model(); drive(); run(500, 0);
`ifdef UART_ARB_ID_HEADER_EN
    abort_words = 2;
`else
    abort_words = 1;
`endif
    add(2, 8'h11, 1'b0); add(2, 8'h22, 1'b0); add(2, 8'h33, 1'b1);
    build_model(); drive(); run(500, abort_words);
    chk("pre_abort_valid", 32'(tx_data_valid), 32'(tx_data_ready ? 1 : 1));
    #2;
    do_reset();
    add(3, 8'h3C, 1'b1); add(0, 8'hE1, 1'b1);
    build_model(); drive(); run(500, 0);

    // Random frames, bubbles and back-pressure.
    max_bub = 3;
    for (int p = 0; p < 8; p++) begin
      if (p % 3 == 0) do_reset();
      for (int i = 0; i < N; i++) begin
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) begin
          nw = $urandom_range(1, 4);
          for (int k = 0; k < nw; k++) add(i, W'($urandom), k == nw - 1);
        end
      end
      build_model(); drive(); run(5000, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
